// File: rtl/mem_ctrl_if.sv
// Bundle of the memory controller's RAM port, fetch/load-store request ports and response signals.
// The controller sits on the slave side; the core and RAM environment sit on the master side.
interface mem_ctrl_if #(
    parameter int XLEN = 32
);
    logic            rdy;
    logic            flush;
    logic            io_buffer_full;
    logic [7:0]      mem_din;
    logic [7:0]      mem_dout;
    logic [XLEN-1:0] mem_a;
    logic            mem_wr;
    logic            icache_mem_enable;
    logic [XLEN-1:0] icache_inst_addr;
    logic            lsb_mem_enable;
    logic            lsb_mem_wr;
    logic [1:0]      lsb_mem_size;
    logic [XLEN-1:0] lsb_mem_addr;
    logic [XLEN-1:0] lsb_mem_wdata;
    logic            mem_busy;
    logic            mem_inst_ready;
    logic [XLEN-1:0] mem_inst;
    logic [XLEN-1:0] mem_inst_addr;
    logic            mem_data_busy;
    logic            mem_data_ready;
    logic [XLEN-1:0] mem_data;

    modport slave (
        input  rdy, flush, io_buffer_full, mem_din,
        input  icache_mem_enable, icache_inst_addr,
        input  lsb_mem_enable, lsb_mem_wr, lsb_mem_size, lsb_mem_addr, lsb_mem_wdata,
        output mem_dout, mem_a, mem_wr,
        output mem_busy, mem_inst_ready, mem_inst, mem_inst_addr,
        output mem_data_busy, mem_data_ready, mem_data
    );

    modport master (
        output rdy, flush, io_buffer_full, mem_din,
        output icache_mem_enable, icache_inst_addr,
        output lsb_mem_enable, lsb_mem_wr, lsb_mem_size, lsb_mem_addr, lsb_mem_wdata,
        input  mem_dout, mem_a, mem_wr,
        input  mem_busy, mem_inst_ready, mem_inst, mem_inst_addr,
        input  mem_data_busy, mem_data_ready, mem_data
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial controller for the shared 8-bit RAM/IO port: one pending slot per requester,
// data-over-instruction arbitration, flush abort of reads, and store throttling on a full IO buffer.
module mem_ctrl #(
    parameter int         XLEN       = 32,
    parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
    input  logic      clk,
    input  logic      rst,
    mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, INST, LOAD, STORE} state_t;

    localparam logic [XLEN-1:0] ADDR_ONE = XLEN'(1);

    state_t          state_q, state_d;
    logic            inst_pend, data_pend, data_wr_q;
    logic [1:0]      data_size_q;
    logic [XLEN-1:0] inst_addr_q, data_addr_q, data_wdata_q;
    logic [2:0]      cnt_q, len_q;
    logic [XLEN-1:0] base_q, a_q, word_q, wdata_q, inst_out_q, inst_addr_out_q, data_out_q;
    logic [7:0]      dout_q;
    logic            wr_q, inst_ready_q, data_ready_q;

    logic            inst_busy, data_busy, inst_in, data_in, inst_req, data_req;
    logic            start_inst, start_data, done;
    logic            sel_wr;
    logic [1:0]      sel_size, byte_sel;
    logic [XLEN-1:0] sel_addr, sel_wdata, inst_sel_addr, next_a, word_asm;

    function automatic logic is_io(input logic [1:0] hi);
        return hi == IO_ADDR_HI;
    endfunction

    // Incoming pulses are taken only when their slot is free and no flush is in progress;
    // a pending store survives a flush, a pending load does not.
    assign inst_in       = bus.icache_mem_enable && !inst_busy && !bus.flush;
    assign data_in       = bus.lsb_mem_enable && !data_busy && !bus.flush;
    assign inst_req      = !bus.flush && (inst_pend || inst_in);
    assign data_req      = (data_pend && (data_wr_q || !bus.flush)) || data_in;
    assign sel_wr        = data_pend ? data_wr_q    : bus.lsb_mem_wr;
    assign sel_size      = data_pend ? data_size_q  : bus.lsb_mem_size;
    assign sel_addr      = data_pend ? data_addr_q  : bus.lsb_mem_addr;
    assign sel_wdata     = data_pend ? data_wdata_q : bus.lsb_mem_wdata;
    assign inst_sel_addr = inst_pend ? inst_addr_q  : bus.icache_inst_addr;
    assign next_a        = a_q + ADDR_ONE;

    // Read byte k-1 arrives during read-state cycle k; merge it into the partial word.
    always_comb begin
        byte_sel = cnt_q[1:0] - 2'd1;
        word_asm = word_q;
        word_asm[{byte_sel, 3'b000} +: 8] = bus.mem_din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          state_q <= IDLE;
        else if (bus.rdy) state_q <= state_d;
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        start_inst = 1'b0;
        start_data = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (data_req) begin
                    start_data = 1'b1;
                    state_d    = sel_wr ? STORE : LOAD;
                end else if (inst_req) begin
                    start_inst = 1'b1;
                    state_d    = INST;
                end
            end
            INST, LOAD: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (cnt_q == len_q) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            STORE: begin
                if (wr_q && cnt_q == len_q - 3'd1) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inst_busy          = inst_pend || state_q == INST;
        data_busy          = data_pend || state_q == LOAD || state_q == STORE;
        bus.mem_busy       = inst_busy;
        bus.mem_data_busy  = data_busy;
        bus.mem_a          = a_q;
        bus.mem_wr         = wr_q;
        bus.mem_dout       = dout_q;
        bus.mem_inst_ready = inst_ready_q;
        bus.mem_inst       = inst_out_q;
        bus.mem_inst_addr  = inst_addr_out_q;
        bus.mem_data_ready = data_ready_q;
        bus.mem_data       = data_out_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_pend    <= 1'b0;
            inst_addr_q  <= '0;
            data_pend    <= 1'b0;
            data_wr_q    <= 1'b0;
            data_size_q  <= '0;
            data_addr_q  <= '0;
            data_wdata_q <= '0;
        end else if (bus.rdy) begin
            if (bus.flush || start_inst) begin
                inst_pend <= 1'b0;
            end else if (inst_in) begin
                inst_pend   <= 1'b1;
                inst_addr_q <= bus.icache_inst_addr;
            end
            if (start_data || (bus.flush && !data_wr_q)) begin
                data_pend <= 1'b0;
            end else if (data_in) begin
                data_pend    <= 1'b1;
                data_wr_q    <= bus.lsb_mem_wr;
                data_size_q  <= bus.lsb_mem_size;
                data_addr_q  <= bus.lsb_mem_addr;
                data_wdata_q <= bus.lsb_mem_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q           <= '0;
            len_q           <= '0;
            base_q          <= '0;
            a_q             <= '0;
            word_q          <= '0;
            wdata_q         <= '0;
            dout_q          <= '0;
            wr_q            <= 1'b0;
            inst_ready_q    <= 1'b0;
            inst_out_q      <= '0;
            inst_addr_out_q <= '0;
            data_ready_q    <= 1'b0;
            data_out_q      <= '0;
        end else if (bus.rdy) begin
            inst_ready_q <= 1'b0;
            data_ready_q <= 1'b0;
            if (start_inst || start_data) begin
                cnt_q  <= '0;
                word_q <= '0;
                if (start_data) begin
                    len_q   <= {1'b0, sel_size} + 3'd1;
                    a_q     <= sel_addr;
                    base_q  <= sel_addr;
                    wdata_q <= sel_wdata;
                    dout_q  <= sel_wdata[7:0];
                    wr_q    <= sel_wr && !(is_io(sel_addr[17:16]) && bus.io_buffer_full);
                end else begin
                    len_q  <= 3'd4;
                    a_q    <= inst_sel_addr;
                    base_q <= inst_sel_addr;
                    wr_q   <= 1'b0;
                end
            end else begin
                unique case (state_q)
                    INST, LOAD: begin
                        if (!bus.flush) begin
                            if (cnt_q != 3'd0) word_q <= word_asm;
                            if (done) begin
                                if (state_q == INST) begin
                                    inst_out_q      <= word_asm;
                                    inst_addr_out_q <= base_q;
                                    inst_ready_q    <= 1'b1;
                                end else begin
                                    data_out_q   <= word_asm;
                                    data_ready_q <= 1'b1;
                                end
                            end else begin
                                if (cnt_q + 3'd1 < len_q) a_q <= next_a;
                                cnt_q <= cnt_q + 3'd1;
                            end
                        end
                    end
                    STORE: begin
                        // A throttled byte keeps its index and retries each cycle.
                        if (!wr_q) begin
                            wr_q <= !(is_io(a_q[17:16]) && bus.io_buffer_full);
                        end else if (done) begin
                            wr_q         <= 1'b0;
                            data_ready_q <= 1'b1;
                        end else begin
                            cnt_q  <= cnt_q + 3'd1;
                            a_q    <= next_a;
                            dout_q <= wdata_q[{cnt_q[1:0] + 2'd1, 3'b000} +: 8];
                            wr_q   <= !(is_io(next_a[17:16]) && bus.io_buffer_full);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a byte RAM model drives mem_din, stimulus pushes expected
// responses into queues and a negedge monitor pops and compares on every ready pulse.
module tb_mem_ctrl;
    typedef struct {
        logic [31:0] data;
        logic [31:0] addr;
        int          cyc;
        bit          chk_data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   t0;

    bit [7:0] ram [int unsigned];
    exp_t     inst_q[$];
    exp_t     data_q[$];

    mem_ctrl_if #(.XLEN(32)) bus ();

    mem_ctrl #(.XLEN(32), .IO_ADDR_HI(2'b11)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: one-cycle read latency, write on the strobe edge.
    always @(posedge clk) begin
        if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
        bus.mem_din <= ram[bus.mem_a];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_inst_ready) begin
                check("inst_ready_expected", 32'(inst_q.size() != 0), 32'd1);
                if (inst_q.size() != 0) begin
                    exp_t e;
                    e = inst_q.pop_front();
                    check("inst_ready_cycle", cyc, e.cyc);
                    check("mem_inst", bus.mem_inst, e.data);
                    check("mem_inst_addr", bus.mem_inst_addr, e.addr);
                end
            end
            if (bus.mem_data_ready) begin
                check("data_ready_expected", 32'(data_q.size() != 0), 32'd1);
                if (data_q.size() != 0) begin
                    exp_t e;
                    e = data_q.pop_front();
                    check("data_ready_cycle", cyc, e.cyc);
                    if (e.chk_data) check("mem_data", bus.mem_data, e.data);
                end
            end
        end
    end

    task automatic fetch(input logic [31:0] addr);
        bus.icache_mem_enable = 1'b1;
        bus.icache_inst_addr  = addr;
    endtask

    task automatic data_req(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata);
        bus.lsb_mem_enable = 1'b1;
        bus.lsb_mem_wr     = wr;
        bus.lsb_mem_size   = size;
        bus.lsb_mem_addr   = addr;
        bus.lsb_mem_wdata  = wdata;
    endtask

    task automatic release_req();
        bus.icache_mem_enable = 1'b0;
        bus.lsb_mem_enable    = 1'b0;
    endtask

    initial begin
        bus.rdy = 1'b1;
        bus.flush = 1'b0;
        bus.io_buffer_full = 1'b0;
        bus.mem_din = 8'h00;
        release_req();
        bus.icache_inst_addr = '0;
        bus.lsb_mem_wr = 1'b0;
        bus.lsb_mem_size = '0;
        bus.lsb_mem_addr = '0;
        bus.lsb_mem_wdata = '0;
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h50; ram[32'h103] = 8'h00;
        ram[32'h200] = 8'h93; ram[32'h201] = 8'h00; ram[32'h202] = 8'h10; ram[32'h203] = 8'h00;
        ram[32'h1000] = 8'hEF; ram[32'h1001] = 8'hBE; ram[32'h1002] = 8'hAD; ram[32'h1003] = 8'hDE;

        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_a", bus.mem_a, 32'h0);
        check("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
        check("rst_mem_dout", 32'(bus.mem_dout), 32'd0);
        check("rst_busy", 32'({bus.mem_busy, bus.mem_data_busy}), 32'd0);
        check("rst_ready", 32'({bus.mem_inst_ready, bus.mem_data_ready}), 32'd0);
        check("rst_mem_inst", bus.mem_inst, 32'h0);
        check("rst_mem_inst_addr", bus.mem_inst_addr, 32'h0);
        check("rst_mem_data", bus.mem_data, 32'h0);
        rst = 1'b0;
        tick();

        // Plain fetch: addresses in T+1..T+4, ready in T+6 with busy already low.
        t0 = cyc;
        fetch(32'h100);
        inst_q.push_back('{32'h00500513, 32'h100, t0 + 6, 1'b1});
        tick();
        release_req();
        for (int i = 0; i < 4; i++) begin
            check("fetch_mem_a", bus.mem_a, 32'h100 + 32'(i));
            check("fetch_mem_wr", 32'(bus.mem_wr), 32'd0);
            check("fetch_busy", 32'(bus.mem_busy), 32'd1);
            if (i < 3) tick();
        end
        tick();
        check("fetch_busy_last", 32'(bus.mem_busy), 32'd1);
        tick();
        check("fetch_busy_ready_cycle", 32'(bus.mem_busy), 32'd0);
        repeat (2) tick();

        // Simultaneous fetch and load: load first, fetch accepted in the load's ready cycle.
        t0 = cyc;
        fetch(32'h200);
        data_req(1'b0, 2'd3, 32'h1000, 32'h0);
        data_q.push_back('{32'hDEADBEEF, 32'h0, t0 + 6, 1'b1});
        inst_q.push_back('{32'h00100093, 32'h200, t0 + 12, 1'b1});
        tick();
        release_req();
        check("arb_load_first", bus.mem_a, 32'h1000);
        check("arb_inst_pending_busy", 32'(bus.mem_busy), 32'd1);
        repeat (6) tick();
        check("arb_fetch_start", bus.mem_a, 32'h200);
        repeat (7) tick();

        // Two-byte store, then a two-byte load back issued in the store's ready cycle.
        t0 = cyc;
        data_req(1'b1, 2'd1, 32'h1001, 32'h0000ABCD);
        data_q.push_back('{32'h0, 32'h0, t0 + 3, 1'b0});
        tick();
        release_req();
        check("st_b0", {bus.mem_a[23:0], bus.mem_dout}, {24'h001001, 8'hCD});
        check("st_b0_wr", 32'(bus.mem_wr), 32'd1);
        tick();
        check("st_b1", {bus.mem_a[23:0], bus.mem_dout}, {24'h001002, 8'hAB});
        check("st_b1_wr", 32'(bus.mem_wr), 32'd1);
        tick();
        check("st_done_wr", 32'(bus.mem_wr), 32'd0);
        t0 = cyc;
        data_req(1'b0, 2'd1, 32'h1001, 32'h0);
        data_q.push_back('{32'h0000ABCD, 32'h0, t0 + 4, 1'b1});
        tick();
        release_req();
        repeat (6) tick();

        // IO store held off while the UART buffer is full for five cycles.
        t0 = cyc;
        bus.io_buffer_full = 1'b1;
        data_req(1'b1, 2'd0, 32'h30000, 32'h0000005A);
        data_q.push_back('{32'h0, 32'h0, t0 + 7, 1'b0});
        tick();
        release_req();
        for (int i = 1; i <= 5; i++) begin
            check("io_throttle_wr", 32'(bus.mem_wr), 32'd0);
            if (i == 5) bus.io_buffer_full = 1'b0;
            tick();
        end
        check("io_release_wr", 32'(bus.mem_wr), 32'd1);
        check("io_release_byte", {bus.mem_a[23:0], bus.mem_dout}, {24'h030000, 8'h5A});
        repeat (2) tick();
        check("io_ram_written", 32'(ram[32'h30000]), 32'h5A);

        // IO load is never throttled.
        bus.io_buffer_full = 1'b1;
        t0 = cyc;
        data_req(1'b0, 2'd0, 32'h30000, 32'h0);
        data_q.push_back('{32'h0000005A, 32'h0, t0 + 3, 1'b1});
        tick();
        release_req();
        check("io_load_addr", bus.mem_a, 32'h30000);
        repeat (4) tick();
        bus.io_buffer_full = 1'b0;

        // Flush during byte 2 of a fetch aborts it silently.
        fetch(32'h100);
        tick();
        release_req();
        repeat (2) tick();
        check("flush_fetch_byte2", bus.mem_a, 32'h102);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_fetch_busy", 32'(bus.mem_busy), 32'd0);
        check("flush_fetch_wr", 32'(bus.mem_wr), 32'd0);
        repeat (8) tick();

        // Request pulses coincident with flush are dropped.
        bus.flush = 1'b1;
        fetch(32'h200);
        data_req(1'b0, 2'd3, 32'h1000, 32'h0);
        tick();
        release_req();
        bus.flush = 1'b0;
        check("flush_drop_busy", 32'({bus.mem_busy, bus.mem_data_busy}), 32'd0);
        repeat (4) tick();

        // Flush during a store: the store still completes and pulses ready.
        t0 = cyc;
        data_req(1'b1, 2'd3, 32'h2000, 32'h11223344);
        data_q.push_back('{32'h0, 32'h0, t0 + 5, 1'b0});
        tick();
        release_req();
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_store_continues", {bus.mem_a[23:0], bus.mem_dout}, {24'h002002, 8'h22});
        check("flush_store_wr", 32'(bus.mem_wr), 32'd1);
        repeat (3) tick();
        t0 = cyc;
        data_req(1'b0, 2'd3, 32'h2000, 32'h0);
        data_q.push_back('{32'h11223344, 32'h0, t0 + 6, 1'b1});
        tick();
        release_req();
        repeat (7) tick();

        // Asynchronous reset in the middle of a load.
        data_req(1'b0, 2'd3, 32'h1000, 32'h0);
        tick();
        release_req();
        tick();
        #2 rst = 1'b1;
        #1;
        check("amid_rst_mem_a", bus.mem_a, 32'h0);
        check("amid_rst_busy", 32'({bus.mem_busy, bus.mem_data_busy}), 32'd0);
        check("amid_rst_mem_data", bus.mem_data, 32'h0);
        check("amid_rst_wr_ready", 32'({bus.mem_wr, bus.mem_data_ready}), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (8) tick();
        t0 = cyc;
        fetch(32'h100);
        inst_q.push_back('{32'h00500513, 32'h100, t0 + 6, 1'b1});
        tick();
        release_req();
        repeat (8) tick();

        for (int i = 0; i < 50 && (inst_q.size() != 0 || data_q.size() != 0); i++) tick();
        check("inst_q_drained", 32'(inst_q.size()), 32'd0);
        check("data_q_drained", 32'(data_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Byte-serial memory controller and arbiter for the single 8-bit RAM/IO port. It is shared between the instruction cache (4-byte fetches) and the load/store buffer (1/2/4-byte loads and stores). It sequences each access one byte per cycle, holds one pending request per requester, arbitrates with data priority, and honours pipeline flush.

Parameters:
- XLEN, 32, address/data width.
- IO_ADDR_HI, 2'b11, value of addr[17:16] that marks the memory-mapped IO region.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  global enable; when low, all state holds
- flush  in  1  misprediction flush
- io_buffer_full  in  1  UART buffer full
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  XLEN  RAM byte address
- mem_wr  out  1  RAM write strobe
- icache_mem_enable  in  1  one-cycle instruction-fetch request pulse
- icache_inst_addr  in  XLEN  fetch address
- lsb_mem_enable  in  1  one-cycle data request pulse
- lsb_mem_wr  in  1  1 = store, 0 = load
- lsb_mem_size  in  2  bytes minus 1 (0, 1 or 3)
- lsb_mem_addr  in  XLEN  data address
- lsb_mem_wdata  in  XLEN  store data, little-endian
- mem_busy  out  1  instruction slot occupied or fetch in flight
- mem_inst_ready  out  1  one-cycle fetch-complete pulse
- mem_inst  out  XLEN  fetched word
- mem_inst_addr  out  XLEN  address of the fetched word
- mem_data_busy  out  1  data slot occupied or data access in flight
- mem_data_ready  out  1  one-cycle load/store-complete pulse
- mem_data  out  XLEN  load result, zero-extended

Behaviour:
- Reset (async):
  - State IDLE, both pending slots empty, counters 0.
  - All outputs 0: mem_a=0, mem_wr=0, mem_dout=0, ready pulses 0, busy flags 0, mem_inst/mem_data/mem_inst_addr=0.
  - Reset mid-access abandons the access; no ready pulse follows.
- rdy=0: no state, output or counter changes.
- Pending slots: an enable pulse is latched into its requester's slot (addr, wr, size, wdata) at the clock edge where it is sampled.
  - A pulse arriving while the corresponding busy flag is high is a protocol violation and is ignored.
- FSM states: IDLE, INST, LOAD, STORE.
  - From IDLE, when a slot is full (or an enable is present that cycle), start an access.
  - Data has priority over instruction. On a tie, data goes first and the instruction stays pending.
- Timing, access accepted in cycle T, N bytes (INST: N=4):
  - Reads: mem_a = addr+i, mem_wr=0 in cycle T+1+i, for i=0..N-1. Byte i arrives on mem_din in cycle T+2+i and is placed at bits [8i+7:8i].
  - Read completion: the ready pulse is high in cycle T+N+2, with the result valid in that same cycle.
  - Stores: mem_a = addr+i, mem_dout = wdata[8i+7:8i], mem_wr=1 in cycle T+1+i. mem_data_ready pulses in cycle T+N+1.
  - The state is IDLE in the pulse cycle, so a pending request can be accepted there, giving back-to-back accesses.
- Busy flags: mem_busy is high from the request-sampling edge through the last cycle before mem_inst_ready, and low in the ready cycle. mem_data_busy is defined the same way for data.
- IO throttle: a store byte whose address has addr[17:16]==IO_ADDR_HI is not issued while io_buffer_full=1.
  - mem_wr=0 and the byte index holds.
  - Issue resumes the cycle after io_buffer_full falls.
  - Loads to IO are never throttled.
- Address arithmetic is XLEN-bit wrap-around.
- Idle outputs: mem_wr=0, and mem_a holds its last value.
- Flush:
  - Any in-flight INST or LOAD is aborted with no ready pulse, and the instruction slot and any data-load slot are cleared.
  - A STORE in flight or pending is committed: it completes normally, including its ready pulse.
  - A request pulse coincident with flush is dropped.
  - The state is IDLE (or STORE) on the next cycle.

Test Plan:
- Fetch: RAM[0x100..0x103]=13 05 50 00. Pulse icache_mem_enable with addr 0x100 in cycle T → mem_a=0x100..0x103 in T+1..T+4; mem_inst_ready pulses in T+6 with mem_inst=0x00500513 and mem_inst_addr=0x100; mem_busy=0 in T+6.
- Arbitration: fetch 0x200 and load size 3 at 0x1000 (RAM=0xDEADBEEF) pulsed in the same cycle → load first, mem_data=0xDEADBEEF; then the fetch starts in the load's ready cycle.
- Store: size 1, addr 0x1001, wdata 0x0000ABCD → mem_wr=1 with bytes CD@0x1001 and AB@0x1002; mem_data_ready pulses 3 cycles after accept; a subsequent 2-byte load returns 0x0000ABCD.
- IO throttle: store size 0 to 0x30000 with io_buffer_full held 1 for 5 cycles → mem_wr stays 0 for those cycles, byte is written the cycle after release, then the ready pulse follows.
- Flush: assert flush during byte 2 of a fetch → no mem_inst_ready and mem_busy=0 next cycle. Assert flush during a store → the store completes and mem_data_ready is still pulsed.
- Async reset mid-load → all outputs 0 immediately, no stale ready pulse afterwards, and a subsequent fetch works.
